// File: rtl/slave_to_master_mux.sv
// slave_to_master_mux
//   AHB return-path multiplexer with built-in default slave.
//   The decoder's slave select and the granted master index are captured
//   during each completing address phase. During the following data phase
//   the selected slave's read data, ready and response are routed to the
//   shared bus. Unmapped NONSEQ/SEQ transfers get the two-cycle ERROR
//   response from the internal default slave.
//
// Ports
//   Hclk, Hresetn  : bus clock, asynchronous active-low reset
//   Hsel           : address-phase slave select (one-hot or zero = unmapped)
//   Htrans         : address-phase HTRANS of the granted master
//   Hmaster        : address-phase granted master index
//   Hrdata_S       : per-slave read data
//   Hreadyout_S    : per-slave HREADYOUT
//   Hresp_S        : per-slave HRESP (0 = OKAY, 1 = ERROR)
//   Hrdata         : bus read data
//   Hready         : bus HREADY
//   Hresp          : bus HRESP
//   Hmaster_dp     : data-phase owner
module slave_to_master_mux #(
    parameter int unsigned NUM_SLAVES   = 4,
    parameter int unsigned NUM_MASTERS  = 2,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MASTER_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                    Hclk,
    input  logic                    Hresetn,
    input  logic [NUM_SLAVES-1:0]   Hsel,
    input  logic [1:0]              Htrans,
    input  logic [MASTER_WIDTH-1:0] Hmaster,
    input  logic [DATA_WIDTH-1:0]   Hrdata_S    [NUM_SLAVES],
    input  logic                    Hreadyout_S [NUM_SLAVES],
    input  logic                    Hresp_S     [NUM_SLAVES],
    output logic [DATA_WIDTH-1:0]   Hrdata,
    output logic                    Hready,
    output logic                    Hresp,
    output logic [MASTER_WIDTH-1:0] Hmaster_dp
);

    localparam int unsigned SEL_W = NUM_SLAVES + 1;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } dflt_state_e;

    logic [SEL_W-1:0]        sel_dp_q;
    logic [SEL_W-1:0]        sel_dp_d;
    logic [MASTER_WIDTH-1:0] mdp_q;
    dflt_state_e             state_q;
    logic                    dflt_ready_q;
    logic                    dflt_resp_q;
    logic                    unmapped_req;
    logic                    hit;

    // Address-phase select to one-hot data-phase select; lowest index wins,
    // no select at all routes to the default slave.
    always_comb begin
        sel_dp_d = '0;
        hit      = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (Hsel[i] && !hit) begin
                sel_dp_d[i] = 1'b1;
                hit         = 1'b1;
            end
        end
        if (!hit) begin
            sel_dp_d[NUM_SLAVES] = 1'b1;
        end
    end

    // Unmapped active transfer (NONSEQ/SEQ) completing its address phase.
    assign unmapped_req = Hready && (Hsel == '0) &&
                          ((Htrans == 2'b10) || (Htrans == 2'b11));

    // Data-phase select and owner, captured only when the bus is ready.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            sel_dp_q <= SEL_W'(1) << NUM_SLAVES;
            mdp_q    <= '0;
        end else if (Hready) begin
            sel_dp_q <= sel_dp_d;
            mdp_q    <= Hmaster;
        end
    end

    // Default slave: OK -> ERR1 (wait, ERROR) -> ERR2 (ready, ERROR).
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q      <= ST_OK;
            dflt_ready_q <= 1'b1;
            dflt_resp_q  <= 1'b0;
        end else begin
            state_q      <= ST_OK;
            dflt_ready_q <= 1'b1;
            dflt_resp_q  <= 1'b0;
            case (state_q)
                ST_OK: begin
                    if (unmapped_req) begin
                        state_q      <= ST_ERR1;
                        dflt_ready_q <= 1'b0;
                        dflt_resp_q  <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state_q      <= ST_ERR2;
                    dflt_ready_q <= 1'b1;
                    dflt_resp_q  <= 1'b1;
                end
                ST_ERR2: begin
                    // ERR2 completes the transfer, so a new unmapped address
                    // phase can chain straight back into ERR1.
                    if (unmapped_req) begin
                        state_q      <= ST_ERR1;
                        dflt_ready_q <= 1'b0;
                        dflt_resp_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_OK;
                end
            endcase
        end
    end

    // Response mux, combinational from the data-phase select.
    always_comb begin
        Hrdata = '0;
        Hready = 1'b0;
        Hresp  = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_dp_q[i]) begin
                Hrdata = Hrdata_S[i];
                Hready = Hreadyout_S[i];
                Hresp  = Hresp_S[i];
            end
        end
        if (sel_dp_q[NUM_SLAVES]) begin
            Hrdata = '0;
            Hready = dflt_ready_q;
            Hresp  = dflt_resp_q;
        end
    end

    assign Hmaster_dp = mdp_q;

endmodule

// File: tb/tb_slave_to_master_mux.sv
module tb_slave_to_master_mux;

    logic        Hclk;
    logic        Hresetn;
    logic [3:0]  Hsel;
    logic [1:0]  Htrans;
    logic [0:0]  Hmaster;
    logic [31:0] Hrdata_S    [4];
    logic        Hreadyout_S [4];
    logic        Hresp_S     [4];
    logic [31:0] Hrdata;
    logic        Hready;
    logic        Hresp;
    logic [0:0]  Hmaster_dp;

    int checks = 0;
    int errors = 0;

    slave_to_master_mux #(
        .NUM_SLAVES  (4),
        .NUM_MASTERS (2),
        .DATA_WIDTH  (32)
    ) dut (
        .Hclk        (Hclk),
        .Hresetn     (Hresetn),
        .Hsel        (Hsel),
        .Htrans      (Htrans),
        .Hmaster     (Hmaster),
        .Hrdata_S    (Hrdata_S),
        .Hreadyout_S (Hreadyout_S),
        .Hresp_S     (Hresp_S),
        .Hrdata      (Hrdata),
        .Hready      (Hready),
        .Hresp       (Hresp),
        .Hmaster_dp  (Hmaster_dp)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    always @(negedge Hclk) begin
        if (Hresetn) begin
            assert ($onehot0(Hsel)) else $error("Hsel multi-hot: %b", Hsel);
        end
    end

    typedef struct {
        logic [3:0]   hsel;
        logic [1:0]   htrans;
        logic [0:0]   hmaster;
        logic [127:0] rd;     // {s3, s2, s1, s0}
        logic [3:0]   rdy;
        logic [3:0]   rsp;
        logic [31:0]  e_rd;
        logic         e_rdy;
        logic         e_rsp;
        logic [0:0]   e_mdp;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(logic [3:0] hsel, logic [1:0] htrans, logic [0:0] hm,
                                logic [127:0] rd, logic [3:0] rdy, logic [3:0] rsp,
                                logic [31:0] e_rd, logic e_rdy, logic e_rsp, logic [0:0] e_mdp);
        vec_t v;
        v.hsel = hsel; v.htrans = htrans; v.hmaster = hm; v.rd = rd;
        v.rdy = rdy; v.rsp = rsp; v.e_rd = e_rd; v.e_rdy = e_rdy;
        v.e_rsp = e_rsp; v.e_mdp = e_mdp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        Hsel    = v.hsel;
        Htrans  = v.htrans;
        Hmaster = v.hmaster;
        for (int s = 0; s < 4; s++) begin
            Hrdata_S[s]    = v.rd[32*s +: 32];
            Hreadyout_S[s] = v.rdy[s];
            Hresp_S[s]     = v.rsp[s];
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_rd, input logic e_rdy,
                           input logic e_rsp, input logic [0:0] e_mdp);
        chk({tag, ".Hrdata"}, Hrdata, e_rd);
        chk({tag, ".Hready"}, 32'(Hready), 32'(e_rdy));
        chk({tag, ".Hresp"}, 32'(Hresp), 32'(e_rsp));
        chk({tag, ".Hmaster_dp"}, 32'(Hmaster_dp), 32'(e_mdp));
    endtask

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [127:0] P = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
    localparam logic [127:0] Q = {32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};

    vec_t idle_v;

    initial begin
        // Inputs applied just after a rising edge; outputs checked at the
        // following falling edge (i.e. during the data phase of the previous
        // address phase).
        vecs[0]  = mk(4'b0010, NSEQ, 1'b1, P, 4'b1111, 4'b0000, 32'h0,        1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(4'b0100, NSEQ, 1'b0, P, 4'b1111, 4'b0000, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
        vecs[2]  = mk(4'b0001, NSEQ, 1'b1, P, 4'b1011, 4'b0000, 32'h22222222, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(4'b0001, NSEQ, 1'b1, Q, 4'b1011, 4'b0000, 32'h55555555, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(4'b0001, NSEQ, 1'b1, P, 4'b1011, 4'b0000, 32'h22222222, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(4'b0001, NSEQ, 1'b1, P, 4'b1111, 4'b0000, 32'h22222222, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(4'b0000, NSEQ, 1'b0, P, 4'b1110, 4'b0001, 32'h11111111, 1'b0, 1'b1, 1'b1);
        vecs[7]  = mk(4'b0000, NSEQ, 1'b0, P, 4'b1111, 4'b0001, 32'h11111111, 1'b1, 1'b1, 1'b1);
        vecs[8]  = mk(4'b0000, SEQ,  1'b1, P, 4'b1111, 4'b0000, 32'h0,        1'b0, 1'b1, 1'b0);
        vecs[9]  = mk(4'b0000, SEQ,  1'b1, P, 4'b1111, 4'b0000, 32'h0,        1'b1, 1'b1, 1'b0);
        vecs[10] = mk(4'b0000, IDLE, 1'b0, P, 4'b1111, 4'b0000, 32'h0,        1'b0, 1'b1, 1'b1);
        vecs[11] = mk(4'b0000, IDLE, 1'b0, P, 4'b1111, 4'b0000, 32'h0,        1'b1, 1'b1, 1'b1);
        vecs[12] = mk(4'b0000, BUSY, 1'b1, P, 4'b1111, 4'b0000, 32'h0,        1'b1, 1'b0, 1'b0);
        vecs[13] = mk(4'b1000, IDLE, 1'b0, P, 4'b1111, 4'b0000, 32'h0,        1'b1, 1'b0, 1'b1);
        vecs[14] = mk(4'b0000, IDLE, 1'b0, P, 4'b1111, 4'b0000, 32'h33333333, 1'b1, 1'b0, 1'b0);
        vecs[15] = mk(4'b0000, IDLE, 1'b0, P, 4'b1111, 4'b0000, 32'h0,        1'b1, 1'b0, 1'b0);
        idle_v   = mk(4'b0000, IDLE, 1'b0, P, 4'b1111, 4'b0000, 32'h0,        1'b1, 1'b0, 1'b0);

        Hresetn = 1'b0;
        drive(idle_v);
        repeat (2) @(negedge Hclk);
        chk_out("reset_initial", 32'h0, 1'b1, 1'b0, 1'b0);
        #2 Hresetn = 1'b1;

        foreach (vecs[k]) begin
            @(posedge Hclk);
            #1 drive(vecs[k]);
            @(negedge Hclk);
            chk_out($sformatf("vec%0d", k), vecs[k].e_rd, vecs[k].e_rdy,
                    vecs[k].e_rsp, vecs[k].e_mdp);
        end

        // Reset mid-data-phase with random slave inputs.
        @(posedge Hclk);
        #1 drive(mk(4'b0010, NSEQ, 1'b1, P, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, 1'b0));
        @(posedge Hclk);
        #1 begin
            Hsel = 4'b0000; Htrans = IDLE; Hmaster = 1'b0;
            for (int s = 0; s < 4; s++) begin
                Hrdata_S[s]    = $urandom | 32'h1;
                Hreadyout_S[s] = 1'($urandom);
                Hresp_S[s]     = 1'b1;
            end
        end
        @(negedge Hclk);
        chk("pre_reset.Hmaster_dp", 32'(Hmaster_dp), 32'h1);
        chk("pre_reset.Hrdata", Hrdata, Hrdata_S[1]);
        #2 Hresetn = 1'b0;
        #1 chk_out("reset_midcycle", 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge Hclk);
        #2 Hresetn = 1'b1;
        drive(idle_v);

        // Reset while the default slave is in ERR1.
        @(posedge Hclk);
        #1 drive(mk(4'b0000, NSEQ, 1'b1, P, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, 1'b0));
        @(posedge Hclk);
        #1 drive(idle_v);
        @(negedge Hclk);
        chk_out("err1_before_reset", 32'h0, 1'b0, 1'b1, 1'b1);
        #2 Hresetn = 1'b0;
        #1 chk_out("reset_in_err1", 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge Hclk);
        #2 Hresetn = 1'b1;
        @(negedge Hclk);
        chk_out("after_reset_ok", 32'h0, 1'b1, 1'b0, 1'b0);

        // Fresh unmapped NONSEQ after release: clean ERR1, ERR2, OK sequence.
        @(posedge Hclk);
        #1 drive(mk(4'b0000, NSEQ, 1'b0, P, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, 1'b0));
        @(posedge Hclk);
        #1 drive(idle_v);
        @(negedge Hclk);
        chk_out("post_rst_err1", 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge Hclk);
        chk_out("post_rst_err2", 32'h0, 1'b1, 1'b1, 1'b0);
        @(negedge Hclk);
        chk_out("post_rst_ok", 32'h0, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slave_to_master_mux.md
# slave_to_master_mux

Return-path multiplexer for the AHB bus, carrying responses from slave to master. It registers the decoder's slave select and the granted master index during each address phase. During the following data phase it routes the selected slave's read data, ready and response onto the shared bus. It also contains the built-in default slave, which answers transfers to unmapped addresses with the two-cycle AHB ERROR response.

## Interface
Parameters:
- NUM_SLAVES, 4, number of decoded slaves; the default slave is internal and extra.
- NUM_MASTERS, 2, number of masters.
- DATA_WIDTH, 32, read data width.
- MASTER_WIDTH, (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1, width of the master index.

Ports:
- Hclk  in  1  bus clock; all state changes on the rising edge.
- Hresetn  in  1  asynchronous, active-low reset.
- Hsel  in  NUM_SLAVES  address-phase slave select from the decoder; one-hot, or all-zero for an unmapped address.
- Htrans  in  2  address-phase HTRANS of the granted master.
- Hmaster  in  MASTER_WIDTH  address-phase granted master index.
- Hrdata_S  in  DATA_WIDTH [NUM_SLAVES]  per-slave read data.
- Hreadyout_S  in  1 [NUM_SLAVES]  per-slave HREADYOUT.
- Hresp_S  in  1 [NUM_SLAVES]  per-slave HRESP (0 = OKAY, 1 = ERROR).
- Hrdata  out  DATA_WIDTH  bus read data.
- Hready  out  1  bus HREADY, fed back to all slaves, masters and the arbiter.
- Hresp  out  1  bus HRESP.
- Hmaster_dp  out  MASTER_WIDTH  data-phase owner; masters qualify Hrdata/Hresp with it.

## Operation
- Data-phase select register sel_dp holds NUM_SLAVES+1 one-hot bits; bit NUM_SLAVES is the default slave.
  - When Hready=1 at a clock edge, sel_dp loads Hsel, or the default bit if Hsel is zero.
  - When Hready=0, sel_dp holds.
  - If Hsel is multi-hot, the lowest index wins; the bench asserts that Hsel is never multi-hot.
- Hmaster_dp loads Hmaster when Hready=1 and holds otherwise.
- Output mux, purely combinational from sel_dp:
  - Slave i selected: Hrdata=Hrdata_S[i], Hready=Hreadyout_S[i], Hresp=Hresp_S[i].
  - Default selected: Hrdata=0; Hready and Hresp come from the default-slave FSM.
- Default-slave FSM has three states: OK, ERR1, ERR2.
  - OK: drives ready=1, resp=0. Goes to ERR1 when Hready=1, Hsel is zero and Htrans is NONSEQ (2'b10) or SEQ (2'b11). Otherwise stays in OK.
  - ERR1: drives ready=0, resp=1. Always goes to ERR2.
  - ERR2: drives ready=1, resp=1. Goes to ERR1 if the address phase completing this cycle is again unmapped NONSEQ/SEQ; otherwise goes to OK.
  - An IDLE or BUSY transfer to an unmapped address gets a zero-wait OKAY and leaves the FSM in OK.
- Transfers to mapped slaves always load sel_dp, including IDLE and BUSY; the slave itself returns OKAY.
- Reset values, asserted asynchronously on Hresetn=0:
  - sel_dp = default, Hmaster_dp = 0, FSM = OK.
  - Outputs therefore read Hready=1, Hresp=0, Hrdata=0.
- Reset mid-transfer, including in ERR1: the in-flight response is abandoned and the outputs take their reset values immediately, with no clock edge needed.

## Timing
- Address phase in cycle N with Hready=1: sel_dp and Hmaster_dp are valid from the edge ending N. The data phase is N+1.
- Zero added latency on the response path: Hrdata, Hready and Hresp follow slave inputs combinationally within the same cycle.
- Wait states: while the selected slave drives Hreadyout_S=0, Hready=0 and sel_dp holds. The next address phase is captured on the edge where Hready returns to 1.
- Back-to-back transfers: a new address phase overlapping a completing data phase loads on the same edge on which the current data phase completes.
- Unmapped NONSEQ in cycle N:
  - N+1: Hready=0, Hresp=1.
  - N+2: Hready=1, Hresp=1.
  - The next address phase is accepted at the end of N+2.
- Hready is never driven 0 with Hresp=0 by the default slave.

## Test plan
- Reset: with slave inputs random, assert Hresetn=0 mid-cycle -> Hready=1, Hresp=0, Hrdata=0 immediately; Hmaster_dp=0.
- Zero-wait read: Hsel=4'b0010, Htrans=NONSEQ, Hmaster=1, Hrdata_S[1]=32'hDEADBEEF, Hreadyout_S[1]=1 -> next cycle Hrdata=32'hDEADBEEF, Hready=1, Hresp=0, Hmaster_dp=1.
- Wait states: slave 2 selected with Hreadyout_S[2]=0 for 3 cycles while Hsel switches to 4'b0001 -> Hready=0 for 3 cycles, sel_dp stays on slave 2, then slave 0 is captured on the release edge.
- Unmapped NONSEQ: Hsel=0, Htrans=NONSEQ -> data-phase cycle 1 Hready=0/Hresp=1, cycle 2 Hready=1/Hresp=1, then Hresp=0.
- Back-to-back unmapped SEQ during ERR2 -> ERR1 again with no OK cycle in between; unmapped IDLE -> single cycle with Hready=1, Hresp=0.
- Reset asserted in ERR1 -> Hready=1, Hresp=0 immediately; after release, the FSM is in OK.
